uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial UART receiver, 8N1 (8E1 with UART_PARITY_EN). It is the receive side of the UART link that the
//  transmit path clocks from the baud divider. Oversamples the asynchronous rx line on clk_in and finds each
//  bit centre with an internal counter. Delivers bytes on a valid/ready interface with a 1-entry holding register.
// PARAMETERS
//  CLKS_PER_BIT  10416  clk_in cycles per bit (100 MHz / 9600 baud); must be >= 4
//  CNT_W         $clog2(CLKS_PER_BIT)  width of the bit-timing counter (derived; do not override)
// PORTS
//  clk_in      in   1   system clock; all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  rx          in   1   serial line, idle high, asynchronous to clk_in
//  rx_data     out  8   received byte, LSB first on the line; stable while rx_valid=1
//  rx_valid    out  1   rx_data holds an unconsumed byte
//  rx_ready    in   1   consumer accepts the byte when rx_valid && rx_ready at a clock edge
//  frame_err   out  1   1-cycle pulse: stop bit sampled low
//  overrun     out  1   sticky: a completed byte was dropped because the holding register was full
//  parity_err  out  1   1-cycle pulse, only with UART_PARITY_EN (otherwise tied 0)
//  clr_err     in   1   synchronous clear of overrun
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, counters=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0,
//    parity_err=0, synchroniser flops=1 (idle line).
//  - rx passes through a 2-flop synchroniser (rx_s); every decision uses rx_s. This adds 2 cycles of latency.
//  - FSM states and transitions:
//    - IDLE: when rx_s=0, go to START with cnt=0.
//    - START: at cnt==CLKS_PER_BIT/2-1 (mid start bit), if rx_s=1 this is a glitch and the FSM returns to IDLE;
//      otherwise go to DATA with cnt=0 and bit_idx=0.
//    - DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into shreg[bit_idx] (LSB first) and reset cnt. After bit_idx=7,
//      go to STOP (or PARITY when enabled).
//    - STOP: at cnt==CLKS_PER_BIT-1, sample the stop bit.
//      - Stop bit=1: the byte is good. Deliver it (see the handshake rules) and go to IDLE.
//      - Stop bit=0: pulse frame_err for one cycle, discard the byte, go to BREAK.
//    - BREAK: wait for rx_s=1, then go to IDLE. A held-low line yields exactly one frame_err.
//  - Sampling point is mid-bit, so the bit centre lands CLKS_PER_BIT/2 after the detected falling edge.
//  - The counter resets to 0 on every state change and never wraps past CLKS_PER_BIT-1.
//  - Handshake at the delivery edge:
//    - rx_valid=0: load rx_data and set rx_valid=1 on the next cycle.
//    - rx_valid=1 and rx_ready=1 on the same edge: the old byte is consumed, the new byte loads, rx_valid stays 1.
//    - rx_valid=1 and rx_ready=0: the new byte is dropped, rx_data is unchanged, and overrun is set.
//  - When no byte is delivered, rx_valid && rx_ready clears rx_valid on the next cycle.
//  - rx_data changes only on a load.
//  - overrun clears on clr_err=1. If clr_err coincides with a new overrun event, the set wins.
//  - Latency: rx_valid rises 3 cycles after the stop-bit sample point (synchroniser 2 + register 1).
// CONFIGURATION
//  UART_PARITY_EN defined:
//    - A PARITY state sits between DATA and STOP and samples one even-parity bit at the bit centre.
//    - On mismatch, parity_err pulses for 1 cycle at the STOP sample, and the byte is discarded.
//    - frame_err takes priority if the stop bit is also bad; only frame_err pulses in that case.
//  UART_PARITY_EN undefined: there is no PARITY state, the frame is 10 bits, and parity_err is constant 0.
// TESTING (bench uses CLKS_PER_BIT=16)
//  1. Send 8'hA5, 8N1, with rx_ready=1 -> rx_valid high 1 cycle, rx_data=8'hA5, no error flags.
//  2. Drive rx low for 6 cycles then high (glitch) -> FSM returns to IDLE, no rx_valid. A following 8'h3C
//     is received correctly.
//  3. Send 8'h01 then 8'h02 back to back with rx_ready=0 -> rx_data=8'h01, overrun=1.
//     Then rx_ready=1 -> 8'h01 consumed. Then clr_err -> overrun=0.
//  4. Send 8'hFF with the stop bit forced 0 and rx held low 40 cycles -> exactly one frame_err pulse,
//     no rx_valid, and recovery on the next frame 8'h55.
//  5. Assert rst_n=0 mid-DATA of 8'hC3 -> all outputs at reset values immediately. The next full frame
//     8'h81 is received correctly.
//  6. With UART_PARITY_EN: 8'h07 sent with parity 0 -> parity_err pulse, byte dropped.
//     With parity 1 -> rx_data=8'h07.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames oversampled on clk_in, bytes delivered through a 1-entry valid/ready holding register.
// Define UART_PARITY_EN to add an even-parity bit between the data and stop bits (8E1).
module uart_rx #(
  parameter  int unsigned CLKS_PER_BIT = 10416,
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  input  logic       clr_err
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

  logic [1:0]       sync_q, sync_d;
  logic             rx_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             deliver;
  logic             drop;
`ifdef UART_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  assign rx_s = sync_q[1];

  // Frame FSM, holding register and error flags
  always_comb begin
    sync_d      = {sync_q[0], rx};
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    deliver     = 1'b0;
    drop        = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d              = '0;
          shreg_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

`ifdef UART_PARITY_EN
      // Even parity: the received parity bit must equal the XOR of the data bits
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ (^shreg_q);
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif

      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
`ifdef UART_PARITY_EN
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              deliver = 1'b1;
            end
`else
            deliver = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A held-low line stays here so it reports only one framing error
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    // A new drop outranks a simultaneous clear
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model plus directed frames with literal expectations.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS = PAR_EN ? 11 : 10;
  // Stop-bit centre on the line, plus 2 synchroniser cycles and 1 output register cycle
  localparam int DLY = NBITS * CPB - CPB / 2 + 3;
  localparam int K_GOOD  = 0;
  localparam int K_FRAME = 1;
  localparam int K_PAR   = 2;

  logic       clk_in   = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clr_err  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err),
    .clr_err   (clr_err)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  int v_cnt    = 0;

  typedef struct {
    int         at;
    logic [7:0] data;
    int         kind;
  } ev_t;
  ev_t evq[$];

  logic       m_valid = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_pe    = 1'b0;
  logic       m_ovr   = 1'b0;
  logic [7:0] m_data  = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // Reference model: each frame resolves at a known cycle into a byte, a framing error or a parity error
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_fe    <= 1'b0;
      m_pe    <= 1'b0;
      m_ovr   <= 1'b0;
      evq.delete();
    end else begin
      m_fe <= 1'b0;
      m_pe <= 1'b0;
      if (clr_err) m_ovr <= 1'b0;
      if (evq.size() != 0 && evq[0].at == cyc + 1) begin
        if (evq[0].kind == K_GOOD) begin
          if (!m_valid || rx_ready) begin
            m_data  <= evq[0].data;
            m_valid <= 1'b1;
          end else begin
            m_ovr <= 1'b1;
          end
        end else begin
          m_fe <= (evq[0].kind == K_FRAME);
          m_pe <= (evq[0].kind == K_PAR);
          if (rx_ready) m_valid <= 1'b0;
        end
        void'(evq.pop_front());
      end else if (rx_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk_in) begin
    check("rx_valid",   32'(rx_valid),   32'(m_valid));
    check("rx_data",    32'(rx_data),    32'(m_data));
    check("frame_err",  32'(frame_err),  32'(m_fe));
    check("overrun",    32'(overrun),    32'(m_ovr));
    check("parity_err", 32'(parity_err), 32'(m_pe));
    if (frame_err === 1'b1)  fe_cnt <= fe_cnt + 1;
    if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
    if (rx_valid === 1'b1)   v_cnt  <= v_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) tick();
  endtask

  task automatic idle(input int n);
    hold(1'b1, n);
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic stop);
    ev_t e;
    e.at   = cyc + DLY;
    e.data = d;
    e.kind = !stop ? K_FRAME : ((PAR_EN && (par != ^d)) ? K_PAR : K_GOOD);
    evq.push_back(e);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
    if (PAR_EN) hold(par, CPB);
    hold(stop, CPB);
  endtask

  task automatic expect_byte(input logic [7:0] exp, input string name, output int lat);
    int n  = 0;
    int t0 = cyc;
    @(negedge clk_in);
    while (rx_valid !== 1'b1 && n < 400) begin
      @(negedge clk_in);
      n++;
    end
    lat = cyc - t0;
    check({name, "_valid"}, 32'(rx_valid), 32'd1);
    check(name, 32'(rx_data), 32'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: stimulus did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int f0;
    int v0;
    int p0;

    repeat (3) @(posedge clk_in);
    #2;
    check("reset_rx_valid",  32'(rx_valid),  32'd0);
    check("reset_rx_data",   32'(rx_data),   32'h00);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun",   32'(overrun),   32'd0);
    rst_n = 1'b1;
    idle(10);

    // Clean byte with consumer always ready
    rx_ready = 1'b1;
    v0 = v_cnt;
    f0 = fe_cnt;
    fork
      send(8'hA5, ^8'hA5, 1'b1);
      expect_byte(8'hA5, "t1_data", lat);
    join
    check("t1_latency", 32'(lat), PAR_EN ? 32'd171 : 32'd155);
    check("t1_valid_cycles", 32'(v_cnt - v0), 32'd1);
    check("t1_no_frame_err", 32'(fe_cnt - f0), 32'd0);

    // Short low glitch must not start a frame
    v0 = v_cnt;
    hold(1'b0, 6);
    idle(30);
    check("t2_glitch_no_valid", 32'(v_cnt - v0), 32'd0);
    fork
      send(8'h3C, ^8'h3C, 1'b1);
      expect_byte(8'h3C, "t2_data", lat);
    join
    idle(8);

    // Two bytes with consumer stalled: second is dropped
    rx_ready = 1'b0;
    fork
      begin
        send(8'h01, ^8'h01, 1'b1);
        send(8'h02, ^8'h02, 1'b1);
      end
      expect_byte(8'h01, "t3_first", lat);
    join
    check("t3_valid_held", 32'(rx_valid), 32'd1);
    check("t3_data_kept",  32'(rx_data),  32'h01);
    check("t3_overrun",    32'(overrun),  32'd1);
    rx_ready = 1'b1;
    tick();
    check("t3_consumed",       32'(rx_valid), 32'd0);
    check("t3_data_unchanged", 32'(rx_data),  32'h01);
    check("t3_overrun_sticky", 32'(overrun),  32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t3_overrun_cleared", 32'(overrun), 32'd0);
    idle(8);

    // Bad stop bit followed by a long low line
    f0 = fe_cnt;
    v0 = v_cnt;
    send(8'hFF, ^8'hFF, 1'b0);
    hold(1'b0, 24);
    idle(40);
    check("t4_one_frame_err", 32'(fe_cnt - f0), 32'd1);
    check("t4_no_valid",      32'(v_cnt - v0),  32'd0);
    fork
      send(8'h55, ^8'h55, 1'b1);
      expect_byte(8'h55, "t4_recover", lat);
    join
    idle(8);

    // Asynchronous reset in the middle of the data bits of 8'hC3
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB / 2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rx_valid",   32'(rx_valid),   32'd0);
    check("t5_rst_rx_data",    32'(rx_data),    32'h00);
    check("t5_rst_frame_err",  32'(frame_err),  32'd0);
    check("t5_rst_overrun",    32'(overrun),    32'd0);
    check("t5_rst_parity_err", 32'(parity_err), 32'd0);
    rx = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    idle(20);
    fork
      send(8'h81, ^8'h81, 1'b1);
      expect_byte(8'h81, "t5_after_reset", lat);
    join
    idle(8);

`ifdef UART_PARITY_EN
    p0 = pe_cnt;
    v0 = v_cnt;
    send(8'h07, 1'b0, 1'b1);
    idle(10);
    check("t6_parity_err_pulse", 32'(pe_cnt - p0), 32'd1);
    check("t6_bad_byte_dropped", 32'(v_cnt - v0),  32'd0);
    fork
      send(8'h07, 1'b1, 1'b1);
      expect_byte(8'h07, "t6_good_parity", lat);
    join
`else
    p0 = pe_cnt;
    send(8'h07, 1'b0, 1'b1);
    idle(10);
    check("t6_parity_err_tied", 32'(pe_cnt - p0), 32'd0);
`endif

    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
